// File: rtl/arb_defs.sv
// Shared definitions for the round-robin arbiter/mux.
// Holds the FSM state encoding and a constant-friendly clog2 used for register sizing.
package arb_defs;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_OWN  = 1'b1
  } arb_state_e;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 << i) < value) begin
        result = i + 1;
      end else begin
        result = result;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational rotating priority encoder: returns the first requester at or after i_start,
// wrapping modulo NREQ.
module rr_pick
  import arb_defs::*;
#(
  parameter int NREQ = 3,
  parameter int IW   = (clog2(NREQ) < 1) ? 1 : clog2(NREQ)
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IW-1:0]   i_start,
  output logic            o_any,
  output logic [IW-1:0]   o_idx
);

  logic [IW-1:0] w_cand;

  // Scan from the farthest candidate back towards i_start so the nearest requester overwrites.
  always_comb begin
    o_any  = 1'b0;
    o_idx  = {IW{1'b0}};
    w_cand = {IW{1'b0}};
    for (int k = NREQ - 1; k >= 0; k--) begin
      w_cand = IW'((int'(i_start) + k) % NREQ);
      o_idx  = i_req[w_cand] ? w_cand : o_idx;
      o_any  = o_any | i_req[w_cand];
    end
  end

endmodule

// File: rtl/rr_arb_mux.sv
// Round-robin arbiter with registered one-hot grant, bounded hold time and output mux
// sharing one output among NREQ requesters.
module rr_arb_mux
  import arb_defs::*;
#(
  parameter int NREQ     = 3,
  parameter int WIDTH    = 1,
  parameter int MAX_HOLD = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] b,
  output logic [WIDTH-1:0]      a,
  output logic [NREQ-1:0]       gnt,
  output logic                  busy,
  output logic                  preempt
);

  localparam int IW = (clog2(NREQ) < 1) ? 1 : clog2(NREQ);
  localparam int HW = (clog2(MAX_HOLD + 1) < 1) ? 1 : clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0]   HOLD_LAST = (MAX_HOLD == 0) ? {HW{1'b0}} : HW'(MAX_HOLD - 1);
  localparam logic [IW-1:0]   IDX_LAST  = IW'(NREQ - 1);
  localparam logic [NREQ-1:0] ONE_HOT0  = {{(NREQ-1){1'b0}}, 1'b1};

  arb_state_e      r_state, w_state_nxt;
  logic [NREQ-1:0] r_gnt, w_gnt_nxt, w_onehot;
  logic [IW-1:0]   r_ptr, w_ptr_nxt, w_ptr_after, w_idx;
  logic [HW-1:0]   r_hold, w_hold_nxt;
  logic            r_busy, r_preempt, w_preempt_nxt;
  logic            w_any, w_owner_req, w_timeout;

  // While OWN, r_ptr always equals owner+1, so a single search start serves both states.
  rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_pick (
    .i_req   (req),
    .i_start (r_ptr),
    .o_any   (w_any),
    .o_idx   (w_idx)
  );

  assign w_owner_req = |(req & r_gnt);
  assign w_timeout   = (MAX_HOLD != 0) && (r_hold == HOLD_LAST);
  assign w_onehot    = ONE_HOT0 << w_idx;
  assign w_ptr_after = (w_idx == IDX_LAST) ? {IW{1'b0}} : w_idx + IW'(1);

  // Next-state, grant, pointer and hold-counter decisions.
  always_comb begin
    w_state_nxt   = r_state;
    w_gnt_nxt     = r_gnt;
    w_ptr_nxt     = r_ptr;
    w_hold_nxt    = r_hold;
    w_preempt_nxt = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_any) begin
          w_state_nxt = ST_OWN;
          w_gnt_nxt   = w_onehot;
          w_hold_nxt  = {HW{1'b0}};
          w_ptr_nxt   = w_ptr_after;
        end else begin
          w_state_nxt = ST_IDLE;
          w_gnt_nxt   = {NREQ{1'b0}};
          w_hold_nxt  = {HW{1'b0}};
        end
      end
      ST_OWN: begin
        if (w_owner_req && !w_timeout) begin
          w_hold_nxt = (r_hold == {HW{1'b1}}) ? r_hold : r_hold + HW'(1);
        end else if (w_any) begin
          // Release or timeout: a timed-out owner is searched last and only loses to another requester.
          w_gnt_nxt     = w_onehot;
          w_hold_nxt    = {HW{1'b0}};
          w_ptr_nxt     = w_ptr_after;
          w_preempt_nxt = w_owner_req && (w_onehot != r_gnt);
        end else begin
          w_state_nxt = ST_IDLE;
          w_gnt_nxt   = {NREQ{1'b0}};
          w_hold_nxt  = {HW{1'b0}};
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_gnt_nxt   = {NREQ{1'b0}};
        w_ptr_nxt   = {IW{1'b0}};
        w_hold_nxt  = {HW{1'b0}};
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_gnt     <= {NREQ{1'b0}};
      r_ptr     <= {IW{1'b0}};
      r_hold    <= {HW{1'b0}};
      r_busy    <= 1'b0;
      r_preempt <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_gnt     <= w_gnt_nxt;
      r_ptr     <= w_ptr_nxt;
      r_hold    <= w_hold_nxt;
      r_busy    <= |w_gnt_nxt;
      r_preempt <= w_preempt_nxt;
    end
  end

  // Output mux: grant is one-hot or zero, so OR-ing the gated lanes selects the owner's data.
  always_comb begin
    a = {WIDTH{1'b0}};
    for (int i = 0; i < NREQ; i++) begin
      a = a | (r_gnt[i] ? b[i*WIDTH +: WIDTH] : {WIDTH{1'b0}});
    end
  end

  assign gnt     = r_gnt;
  assign busy    = r_busy;
  assign preempt = r_preempt;

endmodule

// File: tb/tb_rr_arb_mux.sv
// Self-checking bench for rr_arb_mux: directed scenarios plus randomized traffic against
// a behavioural round-robin model.
module tb_rr_arb_mux;

  localparam int NREQ     = 3;
  localparam int WIDTH    = 4;
  localparam int MAX_HOLD = 4;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] b;
  logic [WIDTH-1:0]      a;
  logic [NREQ-1:0]       gnt;
  logic                  busy;
  logic                  preempt;

  int checks   = 0;
  int failures = 0;

  // Behavioural model: owner index (-1 = idle), rotating pointer, hold count, preempt pulse.
  int   m_owner;
  int   m_ptr;
  int   m_hold;
  logic m_pre;

  always #5 clk = ~clk;

  rr_arb_mux #(
    .NREQ     (NREQ),
    .WIDTH    (WIDTH),
    .MAX_HOLD (MAX_HOLD)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .b       (b),
    .a       (a),
    .gnt     (gnt),
    .busy    (busy),
    .preempt (preempt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = 3'b000;
    tick();
    tick();
    rst = 1'b0;
  endtask

  function automatic int search(input logic [NREQ-1:0] r, input int start);
    for (int k = 0; k < NREQ; k++) begin
      if (r[(start + k) % NREQ]) return (start + k) % NREQ;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_ptr   = 0;
    m_hold  = 0;
    m_pre   = 1'b0;
  endtask

  task automatic model_step(input logic r_in, input logic [NREQ-1:0] rq);
    int w;
    m_pre = 1'b0;
    if (r_in) begin
      model_reset();
    end else if (m_owner < 0) begin
      w = search(rq, m_ptr);
      if (w >= 0) begin
        m_owner = w;
        m_hold  = 0;
        m_ptr   = (w + 1) % NREQ;
      end
    end else if (rq[m_owner] && (MAX_HOLD == 0 || m_hold < MAX_HOLD - 1)) begin
      m_hold = m_hold + 1;
    end else begin
      w = search(rq, (m_owner + 1) % NREQ);
      if (w < 0) begin
        m_owner = -1;
        m_hold  = 0;
      end else begin
        m_pre   = rq[m_owner] && (w != m_owner);
        m_owner = w;
        m_hold  = 0;
        m_ptr   = (w + 1) % NREQ;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req = 3'b111;
    b   = 12'hA5C;
    for (int k = 0; k < 2; k++) begin
      tick();
      checks++;
      if (gnt !== 3'b000 || a !== 4'h0 || busy !== 1'b0 || preempt !== 1'b0) begin
        failures++;
        $display("FAIL reset_hold cyc=%0d got gnt=%b a=%h busy=%b preempt=%b want 000/0/0/0",
                 k, gnt, a, busy, preempt);
      end
    end
    rst = 1'b0;
    tick();
    checks++;
    if (gnt !== 3'b001 || a !== 4'hC || busy !== 1'b1) begin
      failures++;
      $display("FAIL reset_first_grant got gnt=%b a=%h busy=%b want 001/c/1", gnt, a, busy);
    end
  endtask

  task automatic test_single();
    do_reset();
    req = 3'b010;
    b   = 12'h010;
    tick();
    checks++;
    if (gnt !== 3'b010 || a !== 4'h1 || busy !== 1'b1) begin
      failures++;
      $display("FAIL single_grant got gnt=%b a=%h busy=%b want 010/1/1", gnt, a, busy);
    end
    req = 3'b000;
    tick();
    checks++;
    if (gnt !== 3'b000 || a !== 4'h0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL single_release got gnt=%b a=%h busy=%b want 000/0/0", gnt, a, busy);
    end
  endtask

  task automatic test_fairness();
    int e;
    do_reset();
    b   = 12'h321;
    req = 3'b111;
    tick();
    for (int k = 0; k < 4; k++) begin
      e = k % NREQ;
      checks++;
      if (gnt !== (3'b001 << e) || a !== 4'(e + 1)) begin
        failures++;
        $display("FAIL fair_owner k=%0d got gnt=%b a=%h want owner %0d", k, gnt, a, e);
      end
      tick();
      checks++;
      if (gnt !== (3'b001 << e)) begin
        failures++;
        $display("FAIL fair_keep k=%0d got gnt=%b want owner %0d", k, gnt, e);
      end
      req = 3'b111 & ~(3'b001 << e);
      tick();
      req = 3'b111;
      checks++;
      if (gnt !== (3'b001 << ((e + 1) % NREQ)) || busy !== 1'b1) begin
        failures++;
        $display("FAIL fair_handoff k=%0d got gnt=%b busy=%b want owner %0d busy 1",
                 k, gnt, busy, (e + 1) % NREQ);
      end
    end
  endtask

  task automatic test_timeout();
    logic [NREQ-1:0] exp_gnt;
    logic            exp_pre;
    do_reset();
    req = 3'b101;
    for (int k = 1; k <= 9; k++) begin
      tick();
      exp_gnt = (k <= 4) ? 3'b001 : (k <= 8) ? 3'b100 : 3'b001;
      exp_pre = (k == 5 || k == 9);
      checks++;
      if (gnt !== exp_gnt || preempt !== exp_pre) begin
        failures++;
        $display("FAIL timeout cyc=%0d got gnt=%b preempt=%b want %b/%b",
                 k, gnt, preempt, exp_gnt, exp_pre);
      end
    end
  endtask

  task automatic test_sole_owner();
    do_reset();
    req = 3'b001;
    for (int k = 0; k < 10; k++) begin
      tick();
      checks++;
      if (gnt !== 3'b001 || preempt !== 1'b0) begin
        failures++;
        $display("FAIL sole_owner cyc=%0d got gnt=%b preempt=%b want 001/0", k, gnt, preempt);
      end
    end
  endtask

  task automatic test_reset_mid_grant();
    do_reset();
    req = 3'b010;
    tick();
    req = 3'b111;
    tick();
    checks++;
    if (gnt !== 3'b010) begin
      failures++;
      $display("FAIL midrst_owner got gnt=%b want 010", gnt);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (gnt !== 3'b000 || busy !== 1'b0 || preempt !== 1'b0) begin
      failures++;
      $display("FAIL midrst_clear got gnt=%b busy=%b preempt=%b want 000/0/0", gnt, busy, preempt);
    end
    tick();
    checks++;
    if (gnt !== 3'b001) begin
      failures++;
      $display("FAIL midrst_regrant got gnt=%b want 001", gnt);
    end
  endtask

  task automatic test_random();
    logic [NREQ-1:0]  exp_gnt;
    logic [WIDTH-1:0] exp_a;
    do_reset();
    model_reset();
    for (int c = 0; c < 800; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if ($urandom_range(0, 5) == 0) req[i] = ~req[i];
      end
      b   = 12'($urandom);
      rst = ($urandom_range(0, 63) == 0);
      model_step(rst, req);
      tick();
      exp_gnt = (m_owner < 0) ? 3'b000 : (3'b001 << m_owner);
      exp_a   = (m_owner < 0) ? 4'h0 : b[m_owner*WIDTH +: WIDTH];
      checks++;
      if (gnt !== exp_gnt || a !== exp_a || busy !== (m_owner >= 0) || preempt !== m_pre) begin
        failures++;
        $display("FAIL random cyc=%0d got gnt=%b a=%h busy=%b preempt=%b want %b/%h/%b/%b",
                 c, gnt, a, busy, preempt, exp_gnt, exp_a, (m_owner >= 0), m_pre);
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    req = 3'b000;
    b   = 12'h000;
    test_reset();
    test_single();
    test_fairness();
    test_timeout();
    test_sole_owner();
    test_reset_mid_grant();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
